// File: rtl/frame_ext_sequencer_pkg.sv
// Shared state encoding, width helpers and shadow-config type for the
// frame extender line sequencer.
package frame_ext_pkg;

    typedef enum logic [2:0] {
        IDLE_S  = 3'd0,
        FIRST_S = 3'd1,
        TOP_S   = 3'd2,
        BODY_S  = 3'd3,
        BOT_S   = 3'd4
    } seq_state_t;

    // Shadow fields are wide enough for any height/border up to 65535.
    localparam int CFG_W = 16;

    typedef struct packed {
        logic [CFG_W-1:0] top;
        logic [CFG_W-1:0] bottom;
        logic [CFG_W-1:0] lines;
    } ext_cfg_t;

    function automatic int line_w(input int max_res_y);
        return $clog2(max_res_y + 1);
    endfunction

    function automatic int border_w(input int max_border);
        return $clog2(max_border + 1);
    endfunction

endpackage

// File: rtl/frame_ext_sequencer_border_line_counter.sv
// Loadable down-counter with decrement-on-event; saturates at zero.
// Used for remaining source lines and remaining border replays.
module border_line_counter
    import frame_ext_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         is_last_o,
    output logic         is_zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign is_last_o = (cnt_q == W'(1));
    assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/frame_ext_sequencer.sv
// Line-level sequencer choosing passthrough vs. line-buffer replay for border duplication.
// Optional watchdog in replay states: define FRAME_EXT_SEQ_TIMEOUT_EN.
module frame_ext_sequencer
    import frame_ext_pkg::*;
#(
    parameter  int MAX_RES_Y   = 4096,
    parameter  int MAX_BORDER  = 64,
    parameter  int TIMEOUT_CYC = 65535,
    localparam int LINE_W      = line_w(MAX_RES_Y),
    localparam int BORDER_W    = border_w(MAX_BORDER),
    localparam int OUT_W       = LINE_W + BORDER_W + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                src_sof_i,
    input  logic                src_eol_i,
    input  logic                rep_eol_i,
    input  logic                buf_empty_i,
    input  logic [BORDER_W-1:0] cfg_top_i,
    input  logic [BORDER_W-1:0] cfg_bottom_i,
    input  logic [LINE_W-1:0]   cfg_lines_i,
    output logic                pass_en_o,
    output logic                pop_line_o,
    output logic                flush_line_o,
    output logic [OUT_W-1:0]    out_line_cnt_o,
    output logic                frame_done_o,
    output logic                err_o
);

    if (LINE_W > CFG_W || BORDER_W > CFG_W || TIMEOUT_CYC < 1) begin : g_cfg_guard
        $error("frame_ext_sequencer: unsupported parameter set");
    end

    seq_state_t       state_q, state_d;
    ext_cfg_t         cfg_q, cfg_d;
    logic             pass_en_q, pass_en_d, pop_q, pop_d;
    logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
    logic             flush, done, err, start, go_last, pop_set, pop_clr, cnt_inc;
    logic             src_dec, src_last, src_zero, brd_load, brd_dec, brd_last, brd_zero;
    logic [CFG_W-1:0] brd_val;
    logic             wd_fire;

    border_line_counter #(.W(CFG_W)) u_src_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .load_i(start), .load_val_i(cfg_d.lines),
        .dec_i(src_dec), .is_last_o(src_last), .is_zero_o(src_zero)
    );

    border_line_counter #(.W(CFG_W)) u_brd_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .load_i(brd_load), .load_val_i(brd_val),
        .dec_i(brd_dec), .is_last_o(brd_last), .is_zero_o(brd_zero)
    );

`ifdef FRAME_EXT_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            in_rep;

    assign in_rep  = (state_q == TOP_S) || (state_q == BOT_S);
    assign wd_fire = in_rep && !rep_eol_i && (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign wd_d    = (!in_rep || rep_eol_i || wd_fire) ? '0 : wd_q + WD_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        flush   = 1'b0;  done    = 1'b0;  err      = 1'b0;
        start   = 1'b0;  go_last = 1'b0;  pop_set  = 1'b0;
        pop_clr = 1'b0;  cnt_inc = 1'b0;  src_dec  = 1'b0;
        brd_dec = 1'b0;  brd_load = 1'b0; brd_val  = cfg_q.top;

        if (src_sof_i && state_q != IDLE_S) err = 1'b1;

        case (state_q)
            IDLE_S: begin
                if (rep_eol_i) err = 1'b1;
                if (src_sof_i) begin
                    start   = 1'b1;
                    cfg_d   = '{top:    CFG_W'(cfg_top_i),
                                bottom: CFG_W'(cfg_bottom_i),
                                lines:  CFG_W'(cfg_lines_i)};
                    state_d = FIRST_S;
                end
            end
            FIRST_S: begin
                if (rep_eol_i) err = 1'b1;
                if (src_eol_i) begin
                    cnt_inc = 1'b1;
                    src_dec = 1'b1;
                    if (cfg_q.top != '0) begin
                        state_d  = TOP_S;
                        brd_load = 1'b1;
                        pop_set  = 1'b1;
                    end else if (cfg_q.lines == CFG_W'(1)) begin
                        go_last = 1'b1;
                    end else begin
                        flush   = 1'b1;
                        state_d = BODY_S;
                    end
                end
            end
            TOP_S, BOT_S: begin
                if (src_eol_i) err = 1'b1;
                if (rep_eol_i) begin
                    cnt_inc = 1'b1;
                    brd_dec = 1'b1;
                    if (!brd_last) begin
                        pop_set = !brd_zero;
                    end else if (state_q == BOT_S) begin
                        flush   = 1'b1;
                        done    = 1'b1;
                        state_d = IDLE_S;
                    end else if (!src_zero) begin
                        flush   = 1'b1;
                        state_d = BODY_S;
                    end else begin
                        // Single-line frame: the stored line carries straight into the bottom border.
                        go_last = 1'b1;
                    end
                end
            end
            BODY_S: begin
                if (rep_eol_i) err = 1'b1;
                if (src_eol_i) begin
                    cnt_inc = 1'b1;
                    src_dec = 1'b1;
                    if (src_last) go_last = 1'b1;
                    else          flush   = 1'b1;
                end
            end
            default: state_d = IDLE_S;
        endcase

        if (go_last) begin
            if (cfg_q.bottom != '0) begin
                state_d  = BOT_S;
                brd_load = 1'b1;
                brd_val  = cfg_q.bottom;
                pop_set  = 1'b1;
            end else begin
                flush   = 1'b1;
                done    = 1'b1;
                state_d = IDLE_S;
            end
        end

        if (wd_fire) begin
            state_d = IDLE_S;
            err     = 1'b1;
            flush   = 1'b1;
            done    = 1'b0;
            pop_set = 1'b0;
            pop_clr = 1'b1;
        end
    end

    assign pass_en_d = (state_d == IDLE_S) || (state_d == FIRST_S) || (state_d == BODY_S);
    // A fresh request wins over a stale "buffer busy" indication from the previous replay.
    assign pop_d     = pop_set ? 1'b1 : ((pop_clr || !buf_empty_i) ? 1'b0 : pop_q);
    assign out_cnt_d = start ? '0 : (cnt_inc ? out_cnt_q + OUT_W'(1) : out_cnt_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE_S;
            cfg_q     <= '0;
            pass_en_q <= 1'b1;
            pop_q     <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            pass_en_q <= pass_en_d;
            pop_q     <= pop_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign flush_line_o   = flush & ~rst_i;
    assign frame_done_o   = done & ~rst_i;
    assign err_o          = err & ~rst_i;
    assign pop_line_o     = pop_q & ~flush_line_o;
    assign pass_en_o      = pass_en_q;
    assign out_line_cnt_o = out_cnt_q;

endmodule

// File: tb/tb_frame_ext_sequencer.sv
// Scoreboard bench: each frame is expanded into its output line list (source/replay)
// and every expected pulse pattern is derived from that list.
module tb_frame_ext_sequencer;

    localparam int LINE_W   = 13;
    localparam int BORDER_W = 7;
    localparam int OUT_W    = LINE_W + BORDER_W + 1;

    logic clk_i = 1'b0, rst_i = 1'b1;
    logic src_sof_i = 1'b0, src_eol_i = 1'b0, rep_eol_i = 1'b0, buf_empty_i = 1'b1;
    logic [BORDER_W-1:0] cfg_top_i = '0, cfg_bottom_i = '0;
    logic [LINE_W-1:0]   cfg_lines_i = LINE_W'(1);
    logic pass_en_o, pop_line_o, flush_line_o, frame_done_o, err_o;
    logic [OUT_W-1:0] out_line_cnt_o;

    typedef struct {
        bit pass;
        bit flush;
        bit done;
        bit err;
        int cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk = 0, n_pass = 0;
    int   pop_rises = 0, last_total = 0;
    logic pop_prev = 1'b0;

    always #5 clk_i = ~clk_i;

    frame_ext_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .src_sof_i(src_sof_i), .src_eol_i(src_eol_i),
        .rep_eol_i(rep_eol_i), .buf_empty_i(buf_empty_i), .cfg_top_i(cfg_top_i),
        .cfg_bottom_i(cfg_bottom_i), .cfg_lines_i(cfg_lines_i), .pass_en_o(pass_en_o),
        .pop_line_o(pop_line_o), .flush_line_o(flush_line_o), .out_line_cnt_o(out_line_cnt_o),
        .frame_done_o(frame_done_o), .err_o(err_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input bit p, input bit f, input bit d, input bit er, input int c);
        exp_t x;
        x.pass = p; x.flush = f; x.done = d; x.err = er; x.cnt = c;
        sb.push_back(x);
    endtask

    // Monitor: every cycle carrying a sequencing event consumes one expectation.
    always @(negedge clk_i) begin
        if (src_sof_i || src_eol_i || rep_eol_i) begin
            if (sb.size() == 0) begin
                fail("scoreboard_underflow");
            end else begin
                e = sb.pop_front();
                chk("pass_en", int'(pass_en_o), int'(e.pass));
                chk("flush", int'(flush_line_o), int'(e.flush));
                chk("frame_done", int'(frame_done_o), int'(e.done));
                chk("err", int'(err_o), int'(e.err));
                chk("line_cnt_before", int'(out_line_cnt_o), e.cnt);
            end
        end else if (!rst_i && (flush_line_o || frame_done_o || err_o)) begin
            fail("stray_pulse");
        end
        if (pop_line_o && flush_line_o) fail("pop_with_flush");
        if (pop_line_o && !pop_prev) pop_rises++;
        pop_prev = pop_line_o;
    end

    task automatic err_ev(input int kind, input bit pass, input int cnt);
        push(pass, 1'b0, 1'b0, 1'b1, cnt);
        case (kind)
            0:       src_sof_i = 1'b1;
            1:       src_eol_i = 1'b1;
            default: rep_eol_i = 1'b1;
        endcase
        tick();
        src_sof_i = 1'b0; src_eol_i = 1'b0; rep_eol_i = 1'b0;
    endtask

    task automatic wait_pop();
        for (int i = 0; i < 8 && !pop_line_o; i++) tick();
        chk("pop_request", int'(pop_line_o), 1);
    endtask

    task automatic run_frame(input int top, input int bot, input int lines, input int inj_pct);
        bit is_src[$];
        int n;
        bit fl, last;
        is_src.push_back(1'b1);
        repeat (top) is_src.push_back(1'b0);
        repeat (lines - 1) is_src.push_back(1'b1);
        repeat (bot) is_src.push_back(1'b0);
        n = is_src.size();

        cfg_top_i = BORDER_W'(top); cfg_bottom_i = BORDER_W'(bot); cfg_lines_i = LINE_W'(lines);
        pop_rises = 0;
        push(1'b1, 1'b0, 1'b0, 1'b0, last_total);
        src_sof_i = 1'b1; tick(); src_sof_i = 1'b0;
        cfg_top_i = BORDER_W'($urandom); cfg_bottom_i = BORDER_W'($urandom);
        cfg_lines_i = LINE_W'($urandom);
        repeat ($urandom_range(0, 2)) tick();

        for (int k = 0; k < n; k++) begin
            last = (k == n - 1);
            // The stored line is released unless the very next output line replays it.
            fl = last ? 1'b1 : is_src[k+1];
            if (is_src[k]) begin
                if ($urandom_range(0, 99) < inj_pct)
                    err_ev(($urandom_range(0, 1) == 0) ? 0 : 2, 1'b1, k);
                push(1'b1, fl, last, 1'b0, k);
                src_eol_i = 1'b1; tick(); src_eol_i = 1'b0;
            end else begin
                if ($urandom_range(0, 99) < inj_pct)
                    err_ev(($urandom_range(0, 1) == 0) ? 0 : 1, 1'b0, k);
                wait_pop();
                buf_empty_i = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                push(1'b0, fl, last, 1'b0, k);
                rep_eol_i = 1'b1; tick(); rep_eol_i = 1'b0;
                buf_empty_i = 1'b1;
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        tick();
        chk("frame_line_cnt", int'(out_line_cnt_o), n);
        chk("frame_pop_rises", pop_rises, top + bot);
        chk("frame_end_pass_en", int'(pass_en_o), 1);
        last_total = n;
    endtask

    task automatic reset_mid_top();
        cfg_top_i = BORDER_W'(1); cfg_bottom_i = BORDER_W'(0); cfg_lines_i = LINE_W'(3);
        push(1'b1, 1'b0, 1'b0, 1'b0, last_total);
        src_sof_i = 1'b1; tick(); src_sof_i = 1'b0;
        push(1'b1, 1'b0, 1'b0, 1'b0, 0);
        src_eol_i = 1'b1; tick(); src_eol_i = 1'b0;
        chk("rst_pop_request", int'(pop_line_o), 1);
        buf_empty_i = 1'b0; tick();
        // Terminating replay coincides with reset: neither flush nor done may escape.
        push(1'b0, 1'b0, 1'b0, 1'b0, 1);
        rst_i = 1'b1; rep_eol_i = 1'b1; tick();
        rst_i = 1'b0; rep_eol_i = 1'b0; buf_empty_i = 1'b1;
        chk("rst_pass_en", int'(pass_en_o), 1);
        chk("rst_pop", int'(pop_line_o), 0);
        chk("rst_line_cnt", int'(out_line_cnt_o), 0);
        last_total = 0;
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_pass_en", int'(pass_en_o), 1);
        chk("reset_pop", int'(pop_line_o), 0);
        chk("reset_flush", int'(flush_line_o), 0);
        chk("reset_done", int'(frame_done_o), 0);
        chk("reset_err", int'(err_o), 0);
        chk("reset_line_cnt", int'(out_line_cnt_o), 0);
        rst_i = 1'b0;
        tick();

        run_frame(2, 1, 4, 0);
        run_frame(0, 0, 3, 0);
        run_frame(1, 2, 1, 0);
        run_frame(0, 0, 3, 100);
        run_frame(1, 1, 3, 100);
        reset_mid_top();
        run_frame(2, 0, 2, 0);
        for (int f = 0; f < 24; f++)
            run_frame($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 5), 25);

        repeat (2) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/frame_ext_sequencer.md
Name: frame_ext_sequencer

Overview:
- Line-level controller for the frame extender datapath. It decides, for each output line, whether the line comes from the source stream (passthrough) or is replayed from the single-line buffer (top/bottom border duplication).
- Drives the mux select and the line buffer pop/flush commands from handshake events, and counts output lines.
- Border sizes and source height are run-time inputs, latched at start of frame. This replaces fixed parameters.

Parameters:
- MAX_RES_Y, 4096, largest supported source height; sets the line counter width LINE_W = $clog2(MAX_RES_Y+1).
- MAX_BORDER, 64, largest top/bottom border; sets BORDER_W = $clog2(MAX_BORDER+1).
- TIMEOUT_CYC, 65535, watchdog limit in cycles (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- src_sof_i  in  1  source word accepted with tuser=1.
- src_eol_i  in  1  source word accepted with tlast=1 while pass_en_o=1.
- rep_eol_i  in  1  replayed word accepted with tlast=1 while pass_en_o=0.
- buf_empty_i  in  1  line buffer reports no line in replay.
- cfg_top_i  in  BORDER_W  top border lines.
- cfg_bottom_i  in  BORDER_W  bottom border lines.
- cfg_lines_i  in  LINE_W  source lines per frame; must be ≥1.
- pass_en_o  out  1  1 = select source, 0 = select line buffer.
- pop_line_o  out  1  replay request to line buffer.
- flush_line_o  out  1  discard stored line (1-cycle pulse).
- out_line_cnt_o  out  LINE_W+BORDER_W+1  output lines emitted in current frame.
- frame_done_o  out  1  1-cycle pulse at end of extended frame.
- err_o  out  1  1-cycle pulse on protocol violation.

Behaviour:
- Clocking: one clock, clk_i. rst_i is synchronous, active-high.
- Reset values:
  - State = IDLE_S, pass_en_o=1.
  - All other outputs 0; all counters 0.
  - Reset mid-frame behaves the same; no flush is issued.
- States: IDLE_S, FIRST_S, TOP_S, BODY_S, BOT_S. pass_en_o=1 in IDLE_S/FIRST_S/BODY_S and 0 in TOP_S/BOT_S (registered from next_state).
- IDLE_S:
  - On src_sof_i, latch cfg_* into shadow registers, clear out_line_cnt_o, set src_left=lines, go to FIRST_S.
  - Config changes mid-frame have no effect.
- FIRST_S, on src_eol_i:
  - Decrement src_left.
  - If top>0: go to TOP_S and set border counter to top.
  - Else, if lines==1: handle as the last line (below).
  - Else: go to BODY_S.
- TOP_S, on rep_eol_i: decrement counter.
  - If counter was >1: stay.
  - If counter was 1: pulse flush_line_o, then go to BODY_S if src_left>0, else apply the last-line rule.
- BODY_S, on src_eol_i with src_left==1 (last line):
  - If bottom>0: go to BOT_S with counter=bottom and keep the line.
  - Else: pulse flush_line_o, go to IDLE_S, pulse frame_done_o.
- BODY_S, other src_eol_i: pulse flush_line_o in the same cycle (line not retained).
- BOT_S, on rep_eol_i: decrement counter. When it was 1: pulse flush_line_o and frame_done_o, go to IDLE_S.
- Last-line rule with lines==1: top replay, then bottom replay of the same stored line. No flush between them.
- pop_line_o:
  - Set 1 cycle after each event that enters TOP_S/BOT_S, and after each non-final rep_eol_i.
  - Cleared on the first cycle buf_empty_i=0.
  - Never asserted together with flush_line_o.
- out_line_cnt_o increments on every src_eol_i or rep_eol_i, registered with 1-cycle latency.
- Events ignored by state: src_eol_i in TOP_S/BOT_S and rep_eol_i in pass states. Each one pulses err_o and changes nothing else.
- src_sof_i outside IDLE_S pulses err_o and is ignored (no restart).
- Simultaneous src_sof_i and a terminating rep_eol_i in BOT_S: frame ends this cycle; the SOF counts as an error, since IDLE_S is not yet active.

Optional Feature:
- Macro: FRAME_EXT_SEQ_TIMEOUT_EN.
- When defined:
  - A watchdog counter runs while in TOP_S/BOT_S and reloads on rep_eol_i.
  - Reaching TIMEOUT_CYC pulses err_o and flush_line_o, drops pop_line_o and forces IDLE_S, without frame_done_o.
- When undefined: no counter; the sequencer waits indefinitely.

Decomposition:
- Package frame_ext_pkg holds:
  - state enum seq_state_t;
  - LINE_W/BORDER_W width functions;
  - struct ext_cfg_t {top, bottom, lines} used for shadow registers.
- One natural sub-module, border_line_counter: a loadable down-counter with decrement-on-event and is_last flag, instantiated for the top/bottom replay and source-line counts.

Test Plan:
- Nominal: cfg top=2, bottom=1, lines=4; pulse SOF then 4 src_eol interleaved with rep_eol as commanded. Required:
  - pass_en_o sequence 1,0,0,1,1,1,0 per line;
  - pop_line_o rises 3 times;
  - frame_done_o once;
  - out_line_cnt_o=7.
- Zero borders: top=0, bottom=0, lines=3 → pass_en_o stays 1, pop_line_o never asserted, flush_line_o on all 3 eols, out_line_cnt_o=3.
- Single line: top=1, bottom=2, lines=1 → 3 replays, no flush between top and bottom, one flush at final rep_eol, out_line_cnt_o=4.
- Protocol errors:
  - SOF during BODY_S → err_o pulse, state unchanged;
  - rep_eol during BODY_S → err_o pulse, out_line_cnt_o unchanged.
- Reset mid-TOP_S with counter=1 → next cycle IDLE_S, pass_en_o=1, pop_line_o=0, no flush or frame_done_o pulse. A following SOF starts normally.
- With FRAME_EXT_SEQ_TIMEOUT_EN and TIMEOUT_CYC=100: withhold rep_eol in BOT_S → at cycle 100, err_o and flush_line_o pulse and state returns to IDLE_S.
